// File: rtl/mips_pkg.sv
// Shared constants and the buffered write-entry type for the register-file write path.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   // One buffered B-path write; live is cleared when a younger A write to the same register lands.
   typedef struct packed {
      logic              live;
      logic [ADDR_W-1:0] regIdx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer A/B request signals plus the register-file write port and hazard status.
interface regfile_writeback_if #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int DEPTH  = 4
) ();

   logic                      a_valid;
   logic [ADDR_W-1:0]         a_reg;
   logic [DATA_W-1:0]         a_data;
   logic                      b_valid;
   logic                      b_ready;
   logic [ADDR_W-1:0]         b_reg;
   logic [DATA_W-1:0]         b_data;
   logic                      RegWrite;
   logic [ADDR_W-1:0]         WriteRegister;
   logic [DATA_W-1:0]         WriteData;
   logic [(2**ADDR_W)-1:0]    busy_mask;
   logic [$clog2(DEPTH):0]    pending;

   // Producer side: drives requests, observes the write port and status.
   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  b_ready, RegWrite, WriteRegister, WriteData, busy_mask, pending
   );

   // Write-back block side.
   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output b_ready, RegWrite, WriteRegister, WriteData, busy_mask, pending
   );

endinterface

// File: rtl/regfile_writeback_fifo.sv
// Circular buffer for B-path writes with per-entry live bits, squash-by-register and busy mask.
module wb_fifo
   import mips_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        pushReg,
   input  logic [DATA_W-1:0]        pushData,
   input  logic                     pop,
   input  logic                     squash,
   input  logic [ADDR_W-1:0]        squashReg,
   output wb_entry_t                head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [(2**ADDR_W)-1:0]   busyMask
);

   localparam int IW = $clog2(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [IW:0]     wrPtr;
   logic [IW:0]     rdPtr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count = wrPtr - rdPtr;
   assign empty = (wrPtr == rdPtr);
   assign full  = (count == (IW+1)'(DEPTH));
   assign head  = mem[rdPtr[IW-1:0]];

   // Storage and pointers; squash is applied before the push so a same-edge push stays live.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (mem[i].regIdx == squashReg) begin
                  mem[i].live <= 1'b0;
               end
            end
         end
         if (push) begin
            mem[wrPtr[IW-1:0]] <= '{live: 1'b1, regIdx: pushReg, data: pushData};
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
      end
   end

   // Busy mask: OR of onehot(reg) over occupied slots that are still live.
   always_comb begin
      logic [IW-1:0] offs;
      busyMask = '0;
      offs     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs = IW'(i) - rdPtr[IW-1:0];
         if (({1'b0, offs} < count) && mem[i].live) begin
            busyMask[mem[i].regIdx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Merges the never-stalling ALU write path and the buffered B path onto one register-file write port.
module regfile_writeback #(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_writeback_if.slave   bus
);

   mips_pkg::wb_entry_t   head;
   logic                  fifoEmpty;
   logic                  fifoFull;
   logic                  aReq;
   logic                  bAccept;
   logic                  fifoPush;
   logic                  fifoPop;

   // Register 0 is hardwired, so writes to it are dropped on both paths.
   assign aReq     = bus.a_valid && (bus.a_reg != '0);
   assign bAccept  = bus.b_valid && !fifoFull;
   assign fifoPush = bAccept && (bus.b_reg != '0);
   assign fifoPop  = !aReq && !fifoEmpty;

   assign bus.b_ready = !fifoFull;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifoPush),
      .pushReg   (bus.b_reg),
      .pushData  (bus.b_data),
      .pop       (fifoPop),
      .squash    (aReq),
      .squashReg (bus.a_reg),
      .head      (head),
      .empty     (fifoEmpty),
      .full      (fifoFull),
      .count     (bus.pending),
      .busyMask  (bus.busy_mask)
   );

   // Output registers: A wins, else drain the FIFO head (squashed heads give a no-write cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.RegWrite      <= 1'b0;
         bus.WriteRegister <= '0;
         bus.WriteData     <= '0;
      end else if (aReq) begin
         bus.RegWrite      <= 1'b1;
         bus.WriteRegister <= bus.a_reg;
         bus.WriteData     <= bus.a_data;
      end else if (!fifoEmpty) begin
         bus.RegWrite      <= head.live;
         bus.WriteRegister <= head.regIdx;
         bus.WriteData     <= head.data;
      end else begin
         bus.RegWrite      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Cycle-level scoreboard bench for regfile_writeback with a queue-based reference model.
module tb_regfile_writeback;

   localparam int DEPTH = 4;

   logic clk;
   logic rst_n;

   regfile_writeback_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) bus ();

   regfile_writeback #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          live;
      logic [4:0]  r;
      logic [31:0] d;
   } ment_t;

   typedef struct {
      logic        we;
      logic [4:0]  r;
      logic [31:0] d;
      logic [2:0]  pend;
      logic [31:0] busy;
      logic        rdy;
   } exp_t;

   typedef struct {
      logic        aV;
      logic [4:0]  aR;
      logic [31:0] aD;
      logic        expWe;
      logic [4:0]  expR;
      logic [31:0] expD;
   } vec_t;

   ment_t        mq[$];
   exp_t         sb[$];
   logic [31:0]  obs[$];
   logic [4:0]   obsReg[$];
   logic [31:0]  rf [32];
   logic         mWe;
   logic [4:0]   mR;
   logic [31:0]  mD;
   int           compared;
   int           mismatched;
   int           maxPend;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] modelBusy();
      logic [31:0] bm;
      bm = '0;
      foreach (mq[i]) if (mq[i].live) bm[mq[i].r] = 1'b1;
      return bm;
   endfunction

   // One clock: drive at posedge+1, predict, sample at next posedge+1.
   task automatic cycle(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                        input logic bV, input logic [4:0] bR, input logic [31:0] bD,
                        output bit acc);
      exp_t  e;
      exp_t  g;
      ment_t h;
      bit    aReq;
      bus.a_valid = aV;
      bus.a_reg   = aR;
      bus.a_data  = aD;
      bus.b_valid = bV;
      bus.b_reg   = bR;
      bus.b_data  = bD;
      #1;
      chk("b_ready_pre", {31'b0, bus.b_ready}, {31'b0, mq.size() != DEPTH});
      aReq = aV && (aR != 0);
      acc  = bV && (mq.size() != DEPTH);
      if (aReq) begin
         mWe = 1'b1; mR = aR; mD = aD;
         foreach (mq[i]) if (mq[i].r == aR) mq[i].live = 1'b0;
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         mWe = h.live; mR = h.r; mD = h.d;
      end else begin
         mWe = 1'b0;
      end
      if (acc && (bR != 0)) mq.push_back('{live: 1'b1, r: bR, d: bD});
      e.we = mWe; e.r = mR; e.d = mD;
      e.pend = 3'(mq.size());
      e.busy = modelBusy();
      e.rdy  = (mq.size() != DEPTH);
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("RegWrite", {31'b0, bus.RegWrite}, {31'b0, g.we});
      chk("WriteRegister", {27'b0, bus.WriteRegister}, {27'b0, g.r});
      chk("WriteData", bus.WriteData, g.d);
      chk("pending", {29'b0, bus.pending}, {29'b0, g.pend});
      chk("busy_mask", bus.busy_mask, g.busy);
      chk("b_ready", {31'b0, bus.b_ready}, {31'b0, g.rdy});
      if (int'(bus.pending) > maxPend) maxPend = int'(bus.pending);
      if (bus.RegWrite) begin
         rf[bus.WriteRegister] = bus.WriteData;
         if (bus.WriteRegister >= 10 && bus.WriteRegister <= 21) begin
            obs.push_back(bus.WriteData);
            obsReg.push_back(bus.WriteRegister);
         end
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
   endtask

   task automatic checkReset(input string tag);
      chk({tag, "_RegWrite"}, {31'b0, bus.RegWrite}, 32'd0);
      chk({tag, "_WriteRegister"}, {27'b0, bus.WriteRegister}, 32'd0);
      chk({tag, "_WriteData"}, bus.WriteData, 32'd0);
      chk({tag, "_b_ready"}, {31'b0, bus.b_ready}, 32'd1);
      chk({tag, "_busy_mask"}, bus.busy_mask, 32'd0);
      chk({tag, "_pending"}, {29'b0, bus.pending}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      bit   acc;
      int   cnt;
      compared   = 0;
      mismatched = 0;
      maxPend    = 0;
      mWe = 1'b0; mR = '0; mD = '0;
      foreach (rf[i]) rf[i] = '0;
      bus.a_valid = 1'b0; bus.a_reg = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_reg = '0; bus.b_data = '0;
      rst_n = 1'b0;

      vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
      vecs[1] = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd5,  32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 32'hCAFEF00D};
      vecs[3] = '{1'b0, 5'd3,  32'h0000FFFF, 1'b0, 5'd31, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 5'd1,  32'h00000000, 1'b1, 5'd1,  32'h00000000};

      #1;
      checkReset("init");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // A-only vectors
      foreach (vecs[k]) begin
         cycle(vecs[k].aV, vecs[k].aR, vecs[k].aD, 1'b0, 5'd0, 32'd0, acc);
         chk("vec_we", {31'b0, bus.RegWrite}, {31'b0, vecs[k].expWe});
         chk("vec_reg", {27'b0, bus.WriteRegister}, {27'b0, vecs[k].expR});
         chk("vec_data", bus.WriteData, vecs[k].expD);
      end
      idle(1);

      // B latency on empty FIFO: accept at n, write visible during n+2
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h66, acc);
      chk("b_lat_n1_we", {31'b0, bus.RegWrite}, 32'd0);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      chk("b_lat_n2_we", {31'b0, bus.RegWrite}, 32'd1);
      chk("b_lat_n2_data", bus.WriteData, 32'h66);
      idle(1);

      // Fill and backpressure under continuous A traffic
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b1, 5'd30, 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i), acc);
         chk("fill_accept", {31'b0, acc}, {31'b0, i <= 4});
      end
      chk("fill_pending", {29'b0, bus.pending}, 32'd4);
      chk("fill_b_ready", {31'b0, bus.b_ready}, 32'd0);
      chk("fill_busy", bus.busy_mask, 32'h0000001E);
      acc = 1'b0;
      cnt = 0;
      while (!acc && cnt < 10) begin
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105, acc);
         cnt++;
      end
      chk("fill_reg5_accepted", {31'b0, acc}, 32'd1);
      idle(6);
      chk("fill_rf1", rf[1], 32'h101);
      chk("fill_rf4", rf[4], 32'h104);
      chk("fill_rf5", rf[5], 32'h105);

      // Squash: buffered B to r7 overtaken by A to r7
      cycle(1'b1, 5'd30, 32'h0, 1'b1, 5'd7, 32'h11, acc);
      chk("sq_busy_set", {31'b0, bus.busy_mask[7]}, 32'd1);
      cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, acc);
      chk("sq_a_write", bus.WriteData, 32'h22);
      chk("sq_busy_clear", {31'b0, bus.busy_mask[7]}, 32'd0);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, acc);
      chk("sq_pop_nowrite", {31'b0, bus.RegWrite}, 32'd0);
      idle(2);
      chk("sq_rf7", rf[7], 32'h22);

      // Same edge A and B to r9: B is younger and lands last
      cycle(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 32'hBB, acc);
      chk("same_a", bus.WriteData, 32'hAA);
      chk("same_busy", {31'b0, bus.busy_mask[9]}, 32'd1);
      idle(3);
      chk("same_rf9", rf[9], 32'hBB);

      // Wrap: 12 B writes with heavy interleaved A traffic
      obs.delete();
      obsReg.delete();
      maxPend = 0;
      cnt = 0;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         acc = 1'b0;
         while (!acc && cnt < 400) begin
            cycle((cnt % 4) != 3, 5'd30, 32'(cnt), 1'b1, 5'(10 + i), 32'h1000 + 32'(i), acc);
            cnt++;
         end
      end
      idle(8);
      chk("wrap_count", 32'(obs.size()), 32'd12);
      for (int i = 0; i < 12; i++) begin
         if (i < obs.size()) begin
            chk("wrap_order_reg", {27'b0, obsReg[i]}, 32'(10 + i));
            chk("wrap_order_data", obs[i], 32'h1000 + 32'(i));
         end
      end
      chk("wrap_maxpend", 32'(maxPend), 32'd4);

      // Reset asserted mid-cycle with buffered writes
      cycle(1'b1, 5'd30, 32'h1, 1'b1, 5'd12, 32'h5, acc);
      cycle(1'b1, 5'd30, 32'h2, 1'b1, 5'd13, 32'h6, acc);
      #3;
      rst_n = 1'b0;
      #1;
      checkReset("midrst");
      mq.delete();
      mWe = 1'b0; mR = '0; mD = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
